// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_pkg
//   Shared definitions for the multicycle control unit and its datapath.
//   Holds the FSM state encoding, the instruction OPCODE/FUNCT constants,
//   the instruction class encoding, the ULA operation codes and every mux
//   select encoding. The datapath muxes import the same package, so the
//   select values below are the single source of truth.
// ---------------------------------------------------------------------------
package control_unit_pkg;

  // FSM states
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_R_EXEC = 4'd3,
    S_R_WB   = 4'd4,
    S_I_EXEC = 4'd5,
    S_I_WB   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_LW_WB  = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // Instruction classes produced by instr_class
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_INVALID = 3'd6
  } instr_class_t;

  // ULA operation codes
  localparam logic [2:0] ULA_PASS_A = 3'b000;
  localparam logic [2:0] ULA_ADD    = 3'b001;
  localparam logic [2:0] ULA_SUB    = 3'b010;
  localparam logic [2:0] ULA_AND    = 3'b011;
  localparam logic [2:0] ULA_CMP    = 3'b111;

  // ULA operand A mux
  localparam logic       SEL_A_PC  = 1'b0;
  localparam logic       SEL_A_REG = 1'b1;

  // ULA operand B mux
  localparam logic [1:0] SEL_B_REG     = 2'b00;
  localparam logic [1:0] SEL_B_FOUR    = 2'b01;
  localparam logic [1:0] SEL_B_SIGNEXT = 2'b10;
  localparam logic [1:0] SEL_B_SHIFT2  = 2'b11;

  // Memory address mux
  localparam logic [1:0] SEL_MEM_PC     = 2'b00;
  localparam logic [1:0] SEL_MEM_ALUOUT = 2'b01;

  // Register-file write address mux
  localparam logic       SEL_WR_RT = 1'b0;
  localparam logic       SEL_WR_RD = 1'b1;

  // Register-file write data mux
  localparam logic [2:0] SEL_WD_ALUOUT = 3'b000;
  localparam logic [2:0] SEL_WD_LSIZE  = 3'b001;

  // PC source mux
  localparam logic [2:0] SEL_PC_RESULT = 3'b000;
  localparam logic [2:0] SEL_PC_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_PC_JUMP   = 3'b010;
  localparam logic [2:0] SEL_PC_EXCVEC = 3'b100;

  // ULA operation for a (valid) R-type function code
  function automatic logic [2:0] funct_to_ula(input logic [5:0] funct);
    logic [2:0] op;
    op = ULA_ADD;
    case (funct)
      FN_ADD:  op = ULA_ADD;
      FN_SUB:  op = ULA_SUB;
      FN_AND:  op = ULA_AND;
      default: op = ULA_ADD;
    endcase
    return op;
  endfunction

  // Only the arithmetic R-type functions raise an overflow exception
  function automatic logic funct_traps(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/control_unit_instr_class.sv
// ---------------------------------------------------------------------------
// instr_class
//   Purely combinational OPCODE/FUNCT decoder.
//   Ports:
//     opcode  in  6  IR[31:26]
//     funct   in  6  IR[5:0]
//     cls     out 3  instruction class (instr_class_t encoding)
//     invalid out 1  1 when the opcode, or the funct of an R-type, is not
//                    implemented; cls is CLS_INVALID in that case
// ---------------------------------------------------------------------------
module instr_class
  import control_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic       invalid
);

  always_comb begin
    cls = CLS_INVALID;
    case (opcode)
      OP_RTYPE: begin
        if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND)) begin
          cls = CLS_RTYPE;
        end
      end
      OP_ADDI:         cls = CLS_IMM;
      OP_LW:           cls = CLS_LOAD;
      OP_SW:           cls = CLS_STORE;
      OP_BEQ, OP_BNE:  cls = CLS_BRANCH;
      OP_J:            cls = CLS_JUMP;
      default:         cls = CLS_INVALID;
    endcase
  end

  assign invalid = (cls == CLS_INVALID);

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Moore FSM sequencing a multicycle datapath (fetch, decode, execute,
//   memory, write-back, exception). Memory reads take MEM_WAIT cycles
//   (1..7), counted by a 3-bit wait counter that clears on every state entry.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     OPCODE, FUNCT        instruction fields IR[31:26], IR[5:0]
//     Of, Eq               ULA overflow / equal flags (combinational)
//     PC_w .. EPC_w        register write enables
//     ULA_c                ULA operation
//     M_selector_*         datapath mux selects (encodings in the package)
//     reset_out            datapath reset, high while in S_RESET
// ---------------------------------------------------------------------------
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Of,
  input  logic       Eq,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic       ULA_w,
  output logic       EPC_w,
  output logic [2:0] ULA_c,
  output logic       M_selector_A,
  output logic [1:0] M_selector_B,
  output logic [1:0] M_selector_Memory,
  output logic       M_selector_writereg,
  output logic [2:0] M_selector_WDATA,
  output logic [2:0] M_selector_ALUOut,
  output logic       reset_out
);

  // Counter value on the final cycle of a memory wait
  localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT - 1);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] wait_cnt_reg;
  logic [2:0] wait_cnt_next;
  logic [2:0] cls;
  logic       invalid;
  logic       wait_done;

  instr_class u_instr_class (
    .opcode  (OPCODE),
    .funct   (FUNCT),
    .cls     (cls),
    .invalid (invalid)
  );

  assign wait_done = (wait_cnt_reg == LAST_WAIT);

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_RESET;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  if (wait_done) state_next = S_DECODE;
      S_DECODE: begin
        if (invalid) begin
          state_next = S_EXC;
        end else begin
          case (cls)
            CLS_RTYPE:  state_next = S_R_EXEC;
            CLS_IMM:    state_next = S_I_EXEC;
            CLS_LOAD,
            CLS_STORE:  state_next = S_ADDR;
            CLS_BRANCH: state_next = S_BRANCH;
            CLS_JUMP:   state_next = S_JUMP;
            default:    state_next = S_EXC;
          endcase
        end
      end
      // 'and' cannot overflow, so Of only matters for add/sub
      S_R_EXEC: state_next = (Of && funct_traps(FUNCT)) ? S_EXC : S_R_WB;
      S_R_WB:   state_next = S_FETCH;
      S_I_EXEC: state_next = Of ? S_EXC : S_I_WB;
      S_I_WB:   state_next = S_FETCH;
      // Address computation ignores overflow
      S_ADDR:   state_next = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (wait_done) state_next = S_LW_WB;
      S_LW_WB:  state_next = S_FETCH;
      S_MEM_WR: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_EXC:    state_next = S_FETCH;
      default:  state_next = S_RESET;
    endcase
  end

  // The counter only advances while a state repeats (FETCH / MEM_RD waits)
  // and saturates rather than wrapping; any transition clears it.
  always_comb begin
    wait_cnt_next = '0;
    if ((state_next == state_reg) && (wait_cnt_reg != 3'd7)) begin
      wait_cnt_next = wait_cnt_reg + 3'd1;
    end
  end

  // Moore outputs; the branch PC_w is the only input-dependent term
  always_comb begin
    PC_w                = 1'b0;
    MEM_w               = 1'b0;
    IR_w                = 1'b0;
    RB_w                = 1'b0;
    AB_w                = 1'b0;
    ULA_w               = 1'b0;
    EPC_w               = 1'b0;
    ULA_c               = ULA_PASS_A;
    M_selector_A        = SEL_A_PC;
    M_selector_B        = SEL_B_REG;
    M_selector_Memory   = SEL_MEM_PC;
    M_selector_writereg = SEL_WR_RT;
    M_selector_WDATA    = SEL_WD_ALUOUT;
    M_selector_ALUOut   = SEL_PC_RESULT;
    reset_out           = 1'b0;

    case (state_reg)
      S_RESET: reset_out = 1'b1;

      S_FETCH: begin
        M_selector_Memory = SEL_MEM_PC;
        M_selector_A      = SEL_A_PC;
        M_selector_B      = SEL_B_FOUR;
        ULA_c             = ULA_ADD;
        // Latch the instruction and PC+4 only once the read data is valid
        if (wait_done) begin
          IR_w              = 1'b1;
          PC_w              = 1'b1;
          M_selector_ALUOut = SEL_PC_RESULT;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALU_out
        AB_w         = 1'b1;
        M_selector_A = SEL_A_PC;
        M_selector_B = SEL_B_SHIFT2;
        ULA_c        = ULA_ADD;
        ULA_w        = 1'b1;
      end

      S_R_EXEC: begin
        M_selector_A = SEL_A_REG;
        M_selector_B = SEL_B_REG;
        ULA_c        = funct_to_ula(FUNCT);
        ULA_w        = 1'b1;
      end

      S_R_WB: begin
        RB_w                = 1'b1;
        M_selector_writereg = SEL_WR_RD;
        M_selector_WDATA    = SEL_WD_ALUOUT;
      end

      S_I_EXEC, S_ADDR: begin
        M_selector_A = SEL_A_REG;
        M_selector_B = SEL_B_SIGNEXT;
        ULA_c        = ULA_ADD;
        ULA_w        = 1'b1;
      end

      S_I_WB: begin
        RB_w                = 1'b1;
        M_selector_writereg = SEL_WR_RT;
        M_selector_WDATA    = SEL_WD_ALUOUT;
      end

      S_MEM_RD: M_selector_Memory = SEL_MEM_ALUOUT;

      S_LW_WB: begin
        RB_w                = 1'b1;
        M_selector_writereg = SEL_WR_RT;
        M_selector_WDATA    = SEL_WD_LSIZE;
      end

      S_MEM_WR: begin
        M_selector_Memory = SEL_MEM_ALUOUT;
        MEM_w             = 1'b1;
      end

      S_BRANCH: begin
        M_selector_A      = SEL_A_REG;
        M_selector_B      = SEL_B_REG;
        ULA_c             = ULA_CMP;
        M_selector_ALUOut = SEL_PC_ALUOUT;
        PC_w              = ((OPCODE == OP_BEQ) && Eq) ||
                            ((OPCODE == OP_BNE) && !Eq);
      end

      S_JUMP: begin
        PC_w              = 1'b1;
        M_selector_ALUOut = SEL_PC_JUMP;
      end

      S_EXC: begin
        // PC has already advanced by 4, so PC-4 is the faulting address
        M_selector_A      = SEL_A_PC;
        M_selector_B      = SEL_B_FOUR;
        ULA_c             = ULA_SUB;
        EPC_w             = 1'b1;
        PC_w              = 1'b1;
        M_selector_ALUOut = SEL_PC_EXCVEC;
      end

      default: reset_out = 1'b0;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, meaning memory read latency in cycles from address valid to data valid, legal range 1..7.
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-003 SHALL have ports, one per line:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- OPCODE  in  6  IR[31:26]
- FUNCT  in  6  IR[5:0]
- Of  in  1  ULA overflow, combinational
- Eq  in  1  ULA equal flag, combinational
- PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_w, EPC_w  out  1 each  write enables
- ULA_c  out  3  ULA op: 000 pass A, 001 add, 010 sub, 011 and, 111 compare
- M_selector_A  out  1  0=PC, 1=A
- M_selector_B  out  2  00=B, 01=const 4, 10=signExt, 11=shift_2
- M_selector_Memory  out  2  00=PC, 01=ALU_out
- M_selector_writereg  out  1  0=RT, 1=RD
- M_selector_WDATA  out  3  000=ALU_out, 001=LSize_out
- M_selector_ALUOut  out  3  PC source: 000=ULA_result, 001=ALU_out, 010=jump target, 100=exception vector
- reset_out  out  1  datapath reset

Function
REQ-004 SHALL be a Moore FSM: outputs depend only on state and wait counter, except the branch PC_w, which also uses Eq/OPCODE.
REQ-005 SHALL drive all write enables to 0 and all selectors to 0 in any state that does not name them.
REQ-006 S_RESET SHALL last 1 cycle with reset_out=1, then go to FETCH.
REQ-007 FETCH SHALL drive Memory=00, A=0, B=01, ULA_c=001.
- It stays in FETCH for MEM_WAIT cycles, counted by a 3-bit counter.
- On the last cycle only: IR_w=1, PC_w=1, ALUOut=000.
- Next state: DECODE.
REQ-008 DECODE SHALL drive AB_w=1, A=0, B=11, ULA_c=001, ULA_w=1 (branch target into ALU_out).
- R-type (OPCODE 0x00) with FUNCT 0x20/0x22/0x24 -> R_EXEC.
- 0x08 -> I_EXEC.
- 0x23 or 0x2B -> ADDR.
- 0x04 or 0x05 -> BRANCH.
- 0x02 -> JUMP.
- Any other OPCODE or FUNCT -> EXC.
REQ-009 R_EXEC SHALL drive A=1, B=00, ULA_w=1, with ULA_c = 001/010/011 per FUNCT.
- Of=1 with add or sub -> EXC; otherwise -> R_WB.
REQ-010 R_WB SHALL drive RB_w=1, writereg=1, WDATA=000, then go to FETCH.
REQ-011 I_EXEC SHALL drive A=1, B=10, ULA_c=001, ULA_w=1.
- Of=1 -> EXC; otherwise -> I_WB.
- I_WB drives RB_w=1, writereg=0, WDATA=000, then goes to FETCH.
REQ-012 ADDR SHALL drive A=1, B=10, ULA_c=001, ULA_w=1.
- lw -> MEM_RD; sw -> MEM_WR.
- Overflow is ignored.
REQ-013 MEM_RD SHALL drive Memory=01 for MEM_WAIT cycles, then go to LW_WB.
- LW_WB drives RB_w=1, writereg=0, WDATA=001, then goes to FETCH.
REQ-014 MEM_WR SHALL drive Memory=01 and MEM_w=1 for exactly 1 cycle, then go to FETCH.
REQ-015 BRANCH SHALL drive A=1, B=00, ULA_c=111, ALUOut=001.
- PC_w = (OPCODE==0x04 & Eq) | (OPCODE==0x05 & ~Eq).
- Next state: FETCH.
REQ-016 JUMP SHALL drive PC_w=1, ALUOut=010, then go to FETCH.
REQ-017 EXC SHALL drive A=0, B=01, ULA_c=010 (EPC = PC-4), EPC_w=1, PC_w=1, ALUOut=100, then go to FETCH.
REQ-018 The wait counter SHALL clear on every state entry and SHALL never wrap within a state.
REQ-019 The FSM SHALL sample Of and Eq only in the states named above; flags in other states have no effect.

Reset
REQ-020 reset=1 at a clock edge SHALL force S_RESET from any state, aborting the current instruction.
- The following cycle has all write enables 0 and the counter at 0.
REQ-021 Holding reset high SHALL keep the FSM in S_RESET with reset_out=1.

Structure
REQ-022 A shared package SHALL hold the state encoding, the OPCODE/FUNCT constants, the ULA_c codes and every mux-select encoding; the datapath muxes use the same package.
REQ-023 The opcode/funct classification SHALL be one combinational sub-module, instr_class, that outputs the instruction class and an invalid flag.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then MEM_WAIT=2 -> FETCH cycles 2-3 have IR_w=1 and PC_w=1 only in cycle 3; DECODE in cycle 4.
- add with Of=0 -> FETCH(2), DECODE, R_EXEC (ULA_c=001), R_WB (RB_w=1, writereg=1); 5 cycles total.
- sub with Of=1 -> EXC follows R_EXEC; EPC_w=1, PC_w=1, ALUOut=100; RB_w never asserted.
- beq with Eq=0 -> PC_w=0 in BRANCH; bne with Eq=0 -> PC_w=1, ALUOut=001.
- sw -> exactly one MEM_w=1 cycle with Memory=01; lw with MEM_WAIT=3 -> 3 MEM_RD cycles, then LW_WB with WDATA=001.
- reset asserted during MEM_RD -> next cycle is S_RESET with reset_out=1 and no RB_w; OPCODE 0x3F -> EXC.
